// File: rtl/unidade_muldiv.sv
// Iterative RV64M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Operand magnitudes are processed unsigned; the sign is re-applied in FIX.
module unidade_muldiv #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [2:0]       op_r;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] opnd_b;
  logic             neg_q;
  logic             neg_r;
  logic             special;
  logic [CNT_W-1:0] cnt;

  logic             sgn_a, sgn_b, a_neg, b_neg, b_zero, ovf, special_c;
  logic [WIDTH-1:0] a_mag, b_mag, spec_val;
  logic [WIDTH:0]   mul_sum, shifted;
  logic             ge;
  logic [PW-1:0]    prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix, fix_val;

  // Operand decode for an incoming request.
  always_comb begin
    sgn_a     = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    sgn_b     = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    a_neg     = sgn_a & a[WIDTH-1];
    b_neg     = sgn_b & b[WIDTH-1];
    a_mag     = a_neg ? (~a + WIDTH'(1)) : a;
    b_mag     = b_neg ? (~b + WIDTH'(1)) : b;
    b_zero    = (b == '0);
    ovf       = sgn_b & op[2] & (a == MIN_VAL) & (b == '1);
    special_c = op[2] & (b_zero | ovf);
    spec_val  = '0;
    if (b_zero) spec_val = op[1] ? a : '1;
    else        spec_val = op[1] ? '0 : a;
  end

  // One iteration step for each algorithm.
  always_comb begin
    mul_sum = {1'b0, prod[PW-1:WIDTH]} + (prod[0] ? {1'b0, opnd_b} : '0);
    shifted = {rem, quo[WIDTH-1]};
    ge      = (shifted >= {1'b0, opnd_b});
  end

  // Sign correction and result selection.
  always_comb begin
    prod_fix = neg_q ? (~prod + PW'(1)) : prod;
    q_fix    = neg_q ? (~quo + WIDTH'(1)) : quo;
    r_fix    = neg_r ? (~rem + WIDTH'(1)) : rem;
    fix_val  = '0;
    if (special)          fix_val = quo;
    else if (op_r[2])     fix_val = op_r[1] ? r_fix : q_fix;
    else if (op_r == 3'd0) fix_val = prod_fix[WIDTH-1:0];
    else                  fix_val = prod_fix[PW-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      op_r    <= '0;
      prod    <= '0;
      rem     <= '0;
      quo     <= '0;
      opnd_b  <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      special <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op_r    <= op;
            cnt     <= '0;
            busy    <= 1'b1;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            prod    <= {WIDTH'(0), a_mag};
            rem     <= '0;
            opnd_b  <= b_mag;
            special <= special_c;
            if (special_c) begin
              quo   <= spec_val;
              state <= FIX;
            end else begin
              quo   <= a_mag;
              state <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (!op_r[2]) begin
            prod <= {mul_sum, prod[WIDTH-1:1]};
          end else begin
            rem <= ge ? WIDTH'(shifted - {1'b0, opnd_b}) : shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ge};
          end
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          result <= fix_val;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_muldiv.sv
// Directed bench for unidade_muldiv (WIDTH=64): results, latency, special cases, ignored starts, reset.
module tb_unidade_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [63:0] a, b;
  logic        busy, done;
  logic [63:0] result;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  unidade_muldiv #(.WIDTH(64)) dut (
    .clk(clk), .Reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, optionally pulse a stray start at cycle 'poke', wait for done.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [63:0] x,
                        input logic [63:0] y, input logic [63:0] exp, input int lat,
                        input int poke);
    int   cyc;
    logic busy_ok;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 'x; a = {$urandom, $urandom}; b = {$urandom, $urandom};
    cyc = 1;
    busy_ok = 1'b1;
    check({tag, "_done_drop"}, 64'(done), 64'd0);
    while (!done && cyc < 200) begin
      if (!busy) busy_ok = 1'b0;
      if (cyc == poke) begin start = 1'b1; op = 3'd0; a = 64'd99; b = 64'd99; end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_busy_while_run"}, 64'(busy_ok), 64'd1);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_result"}, result, exp);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", result, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("mul_7_m3", 3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66, -1);
    // Output stays in place once the unit returns to idle.
    repeat (2) @(posedge clk);
    #1;
    check("hold_done", 64'(done), 64'd0);
    check("hold_busy", 64'(busy), 64'd0);
    check("hold_result", result, 64'hFFFF_FFFF_FFFF_FFEB);

    run_op("mulhu_ones", 3'd3, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 66, -1);
    run_op("mulh_m1_m1", 3'd1, ONES, ONES, 64'd0, 66, -1);
    run_op("mulh_min_min", 3'd1, MIN, MIN, 64'h4000_0000_0000_0000, 66, -1);
    run_op("mulhsu_m1_2", 3'd2, ONES, 64'd2, ONES, 66, -1);
    run_op("div_m20_3", 3'd4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 66, -1);
    run_op("rem_m20_3", 3'd6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 66, -1);
    run_op("div_20_m3", 3'd4, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, 66, -1);
    run_op("rem_20_m3", 3'd6, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 66, -1);
    run_op("divu_20_3_poke", 3'd5, 64'd20, 64'd3, 64'd6, 66, 5);
    run_op("remu_20_3", 3'd7, 64'd20, 64'd3, 64'd2, 66, -1);
    run_op("divu_min_ones", 3'd5, MIN, ONES, 64'd0, 66, -1);
    run_op("div_by0", 3'd4, 64'h1234, 64'd0, ONES, 2, -1);
    run_op("rem_by0", 3'd6, 64'h1234, 64'd0, 64'h1234, 2, -1);
    run_op("divu_by0", 3'd5, 64'h1234, 64'd0, ONES, 2, -1);
    run_op("remu_by0", 3'd7, 64'h1234, 64'd0, 64'h1234, 2, -1);
    run_op("div_ovf_poke", 3'd4, MIN, ONES, MIN, 2, 1);
    run_op("rem_ovf", 3'd6, MIN, ONES, 64'd0, 2, -1);

    // Reset in the middle of a multiply.
    start = 1'b1; op = 3'd0; a = 64'd5; b = 64'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_result", result, 64'd0);
    @(posedge clk); #1;
    run_op("post_rst_mul", 3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
